shared_reg_arbiter: RTL and testbench

//   Round-robin arbiter sharing one DATA_W-bit register bank among N_REQ requesters.
//   The bank is built from reset-clear D flip-flops.
//   A requester holds the bank for a burst of writes until it releases it.

---
 rtl/shared_reg_arb_pkg.sv | 10 +
 rtl/rr_pick.sv | 27 ++
 rtl/shared_reg_arbiter.sv | 89 ++++++++
 tb/tb_shared_reg_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/shared_reg_arb_pkg.sv
// shared_reg_arb_pkg: shared types, default sizes and width helper for shared_reg_arbiter
package shared_reg_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int HOLD_MAX_DEF = 15;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request scanning from ptr upward with wrap
module rr_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);
  logic [IDX_W-1:0] w_idx;
  // scan farthest offset first so the nearest set request is the final assignment
  always_comb begin
    any = 1'b0;
    winner = '0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_idx = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req[w_idx]) begin
        any = 1'b1;
        winner = w_idx;
      end
    end
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin owner of a shared register bank, burst writes until release.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        last,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [IDX_W-1:0]        owner,
  output logic [DATA_W-1:0]       q,
  output logic                    q_valid,
  output logic                    timeout
);
  state_t              r_state;
  logic [N_REQ-1:0]    r_gnt;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    r_ptr;
  logic [DATA_W-1:0]   r_q;
  logic                r_q_valid;
  logic                w_any;
  logic [IDX_W-1:0]    w_winner;
  logic                w_own_req;
  logic                w_nat;
  logic                w_force;
  logic                w_rel;
  logic [IDX_W-1:0]    w_nxt_ptr;
  logic [DATA_W-1:0]   w_wdata;
  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req(req),
    .ptr(r_ptr),
    .any(w_any),
    .winner(w_winner)
  );
  assign w_own_req = req[r_owner];
  assign w_wdata = wdata[int'(r_owner)*DATA_W +: DATA_W];
  assign w_nat = !w_own_req || last[r_owner];
  assign w_rel = w_nat || w_force;
  assign w_nxt_ptr = (int'(r_owner) == N_REQ - 1) ? '0 : r_owner + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_owner <= '0;
      r_ptr <= '0;
      r_q <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= (r_state == GRANT) && w_own_req;
      if (r_state == GRANT && w_own_req) r_q <= w_wdata;
      if (r_state == IDLE && w_any) begin
        r_state <= GRANT;
        r_gnt <= N_REQ'(1) << w_winner;
        r_owner <= w_winner;
      end else if (r_state == GRANT && w_rel) begin
        r_state <= IDLE;
        r_gnt <= '0;
        r_ptr <= w_nxt_ptr;
      end
    end
  end
`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = idx_w(HOLD_MAX + 1);
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_timeout;
  assign w_force = (r_state == GRANT) && (r_hold_cnt == CNT_W'(HOLD_MAX - 1));
  // counter rests at zero in IDLE so it is already cleared on entry to GRANT
  always_ff @(posedge clk) begin
    if (rst || r_state == IDLE) r_hold_cnt <= '0;
    else r_hold_cnt <= r_hold_cnt + 1'b1;
    r_timeout <= !rst && w_force && !w_nat;
  end
  assign timeout = r_timeout;
`else
  assign w_force = 1'b0;
  assign timeout = 1'b0;
`endif
  assign gnt = r_gnt;
  assign owner = r_owner;
  assign q = r_q;
  assign q_valid = r_q_valid;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed scenarios plus random traffic against a cycle reference model
module tb_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, last, gnt, prev_gnt;
  logic [N*W-1:0] wdata;
  logic [1:0] owner;
  logic [W-1:0] q;
  logic q_valid, timeout;
  int total = 0, bad = 0, to_cnt = 0;
  bit m_busy, m_qv, m_to;
  int m_owner, m_ptr, m_held;
  logic [W-1:0] m_q;
  int grants[$];
  logic [W-1:0] qs[$];
  always #5 clk = ~clk;
  shared_reg_arbiter #(.N_REQ(N), .DATA_W(W), .HOLD_MAX(H)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .wdata(wdata),
    .gnt(gnt), .owner(owner), .q(q), .q_valid(q_valid), .timeout(timeout)
  );
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  function automatic logic [N*W-1:0] wd(int i, logic [W-1:0] v);
    return (N*W)'(v) << (i * W);
  endfunction
  // reference: idle picks nearest requester at or after ptr, grant writes owner data until release
  task automatic model_step();
    int o;
    bit nat, frc, done;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_q = '0; m_qv = 0; m_to = 0; m_held = 0;
      return;
    end
    m_qv = 0;
    m_to = 0;
    if (!m_busy) begin
      done = 0;
      for (int d = 0; d < N; d++)
        if (!done && req[(m_ptr + d) % N]) begin
          done = 1; m_busy = 1; m_owner = (m_ptr + d) % N; m_held = 0;
        end
    end else begin
      o = m_owner;
      if (req[o]) begin m_q = wdata[o*W +: W]; m_qv = 1; end
      m_held++;
      nat = !req[o] || last[o];
      frc = TO_EN && m_held == H;
      if (nat || frc) begin m_busy = 0; m_ptr = (o + 1) % N; m_to = frc && !nat; end
    end
  endtask
  task automatic cyc(logic r, logic [N-1:0] rq, logic [N-1:0] ls, logic [N*W-1:0] d);
    rst = r; req = rq; last = ls; wdata = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("gnt", 32'(gnt), m_busy ? 32'(1) << m_owner : 32'd0);
    chk("owner", 32'(owner), 32'(m_owner));
    chk("q", 32'(q), 32'(m_q));
    chk("q_valid", 32'(q_valid), 32'(m_qv));
    chk("timeout", 32'(timeout), 32'(m_to));
    if (gnt != 0 && prev_gnt == 0)
      for (int i = 0; i < N; i++) if (gnt[i]) grants.push_back(i);
    if (q_valid) qs.push_back(q);
    if (timeout) to_cnt++;
    prev_gnt = gnt;
  endtask
  initial begin
    prev_gnt = '0;
    // reset with all requests asserted
    cyc(1, 4'b1111, 4'b0000, '0);
    cyc(1, 4'b1111, 4'b0000, '0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_owner", 32'(owner), 0);
    // single requester
    cyc(0, 4'b0100, 4'b0100, wd(2, 8'hA5));
    chk("single_gnt", 32'(gnt), 32'h4);
    cyc(0, 4'b0100, 4'b0100, wd(2, 8'hA5));
    chk("single_q", 32'(q), 32'hA5);
    chk("single_qv", 32'(q_valid), 1);
    chk("single_rel", 32'(gnt), 0);
    cyc(0, 4'b0000, 4'b0000, '0);
    // round robin under full load
    cyc(1, 4'b0000, 4'b0000, '0);
    grants.delete();
    repeat (10) cyc(0, 4'b1111, 4'b1111, (N*W)'($urandom));
    chk("rr_count", 32'(grants.size()), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr_order", 32'(grants[i]), 32'(i % N));
    // burst from owner 1 while requester 3 writes FF
    cyc(1, 4'b0000, 4'b0000, '0);
    grants.delete();
    qs.delete();
    cyc(0, 4'b1010, 4'b0000, wd(1, 8'h11) | wd(3, 8'hFF));
    cyc(0, 4'b1010, 4'b0000, wd(1, 8'h11) | wd(3, 8'hFF));
    cyc(0, 4'b1010, 4'b0000, wd(1, 8'h22) | wd(3, 8'hFF));
    cyc(0, 4'b1010, 4'b0010, wd(1, 8'h33) | wd(3, 8'hFF));
    cyc(0, 4'b1000, 4'b1000, wd(3, 8'hFF));
    chk("burst_len", 32'(qs.size()), 3);
    if (qs.size() == 3) begin
      chk("burst_q0", 32'(qs[0]), 32'h11);
      chk("burst_q1", 32'(qs[1]), 32'h22);
      chk("burst_q2", 32'(qs[2]), 32'h33);
    end
    cyc(0, 4'b1000, 4'b1000, wd(3, 8'hFF));
    chk("burst_next", 32'(grants.size() == 2 ? grants[1] : -1), 3);
    // reset during owner 0's second write
    cyc(1, 4'b0000, 4'b0000, '0);
    cyc(0, 4'b0001, 4'b0000, wd(0, 8'h5A));
    cyc(0, 4'b0001, 4'b0000, wd(0, 8'h5A));
    cyc(1, 4'b0001, 4'b0000, wd(0, 8'h77));
    chk("midrst_q", 32'(q), 0);
    chk("midrst_gnt", 32'(gnt), 0);
    cyc(0, 4'b0000, 4'b0000, '0);
    chk("midrst_idle", 32'(gnt), 0);
`ifdef ARB_TIMEOUT_EN
    cyc(1, 4'b0000, 4'b0000, '0);
    grants.delete();
    to_cnt = 0;
    repeat (9) cyc(0, 4'b0011, 4'b0000, (N*W)'($urandom));
    chk("to_pulses", 32'(to_cnt), 1);
    chk("to_next", 32'(grants.size() >= 2 ? grants[1] : -1), 1);
`endif
    // random traffic
    repeat (400)
      cyc($urandom_range(0, 49) == 0, N'($urandom), N'($urandom & $urandom), (N*W)'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
